// File: rtl/sprite_motion_controller.sv
`default_nettype none
// ============================================================================
// Module      : sprite_motion_controller
// Description : Once per frame, walks every sprite's word 0 ({ypos,xpos}) in
//               the shared sprite RAM, applies the per-sprite signed velocity
//               with edge bounce, and writes word 0 back. Yields the RAM while
//               the renderer asserts ram_busy.
//               Optional macro SPRITE_MOTION_GRAVITY_EN adds a +1 per frame
//               downward acceleration to dy.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_controller #(
    parameter int NB         = 5,
    parameter int START_LINE = 256,
    parameter int XMAX       = 240,
    parameter int YMAX       = 240
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    hpos,
    input  logic [8:0]    vpos,
    input  logic          enable,
    input  logic          ram_busy,
    output logic [NB:0]   ram_addr,
    output logic [15:0]   ram_din,
    input  logic [15:0]   ram_data,
    output logic          ram_we,
    input  logic          vel_we,
    input  logic [NB-1:0] vel_index,
    input  logic [3:0]    vel_dx,
    input  logic [3:0]    vel_dy,
    output logic          active,
    output logic          frame_done
);

    localparam int         c_num_sprites = 1 << NB;
    localparam logic [8:0] c_start_line  = 9'(START_LINE);
    localparam logic [9:0] c_xmax        = 10'(XMAX);
    localparam logic [9:0] c_ymax        = 10'(YMAX);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_CALC = 3'd4,
        S_WR   = 3'd5,
        S_NEXT = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NB-1:0]   r_idx;
    logic [7:0]      r_x, r_y, r_nx, r_ny;
    logic [3:0]      r_ndx, r_ndy;
    logic            r_frame_done;
    logic [3:0]      r_vdx [c_num_sprites];
    logic [3:0]      r_vdy [c_num_sprites];

    logic            w_launch;
    logic            w_last;
    logic [3:0]      w_dx, w_dy_eff;
    logic [11:0]     w_xmove, w_ymove;

    // -8 has no positive counterpart in 4 bits, so it is stored as -7
    function automatic logic [3:0] clip_vel(input logic [3:0] v);
        return (v == 4'b1000) ? 4'b1001 : v;
    endfunction

    // One axis step: returns {new position, new velocity} with clamp and bounce
    function automatic logic [11:0] move_axis(input logic [7:0] pos,
                                              input logic [3:0] vel,
                                              input logic [9:0] lim);
        logic [9:0] s;
        s = {2'b00, pos} + {{6{vel[3]}}, vel};
        if (s[9])
            move_axis = {8'd0, ~vel + 4'd1};
        else if (s > lim)
            move_axis = {lim[7:0], ~vel + 4'd1};
        else
            move_axis = {s[7:0], vel};
    endfunction

    assign w_launch = enable && (vpos == c_start_line) && (hpos == 9'd0);
    assign w_last   = &r_idx;
    assign w_dx     = r_vdx[r_idx];

`ifdef SPRITE_MOTION_GRAVITY_EN
    assign w_dy_eff = (r_vdy[r_idx] == 4'd7) ? 4'd7 : r_vdy[r_idx] + 4'd1;
`else
    assign w_dy_eff = r_vdy[r_idx];
`endif

    assign w_xmove = move_axis(r_x, w_dx, c_xmax);
    assign w_ymove = move_axis(r_y, w_dy_eff, c_ymax);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and RAM-side outputs
    always_comb begin
        w_next   = r_state;
        ram_addr = {r_idx, 1'b0};
        ram_din  = {r_ny, r_nx};
        ram_we   = 1'b0;
        active   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (w_launch) w_next = S_RD;
            S_RD:   w_next = S_WAIT;
            S_WAIT: w_next = S_CAP;
            S_CAP:  w_next = S_CALC;
            S_CALC: w_next = S_WR;
            S_WR: begin
                w_next = S_NEXT;
                ram_we = !ram_busy;
            end
            S_NEXT: w_next = w_last ? S_IDLE : S_RD;
            default: w_next = S_IDLE;
        endcase
        // While stalled the sprite is parked at RD so it resumes with a fresh
        // read; NEXT is past the write and simply waits.
        if (ram_busy && (r_state != S_IDLE))
            w_next = (r_state == S_NEXT) ? S_NEXT : S_RD;
    end

    // Sprite index, captured position, computed move and completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_x          <= 8'd0;
            r_y          <= 8'd0;
            r_nx         <= 8'd0;
            r_ny         <= 8'd0;
            r_ndx        <= 4'd0;
            r_ndy        <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == S_NEXT) && !ram_busy && w_last;
            if ((r_state == S_IDLE) && w_launch)
                r_idx <= '0;
            if ((r_state == S_NEXT) && !ram_busy)
                r_idx <= r_idx + 1'b1;
            if ((r_state == S_CAP) && !ram_busy) begin
                r_x <= ram_data[7:0];
                r_y <= ram_data[15:8];
            end
            if ((r_state == S_CALC) && !ram_busy) begin
                r_nx  <= w_xmove[11:4];
                r_ndx <= w_xmove[3:0];
                r_ny  <= w_ymove[11:4];
                r_ndy <= w_ymove[3:0];
            end
        end
    end

    assign frame_done = r_frame_done;

    // Velocity table: WR commits the bounced velocity, an external write wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_num_sprites; i++) begin
                r_vdx[i] <= 4'd0;
                r_vdy[i] <= 4'd0;
            end
        end else begin
            if ((r_state == S_WR) && !ram_busy) begin
                r_vdx[r_idx] <= r_ndx;
                r_vdy[r_idx] <= r_ndy;
            end
            if (vel_we) begin
                r_vdx[vel_index] <= clip_vel(vel_dx);
                r_vdy[vel_index] <= clip_vel(vel_dy);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_motion_controller
// Description : Self-checking bench for sprite_motion_controller with a
//               behavioural sprite-motion model and a synchronous RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_motion_controller;

    localparam int NB   = 5;
    localparam int N    = 32;
    localparam int XMAX = 240;
    localparam int YMAX = 240;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  hpos = 9'd1;
    logic [8:0]  vpos = 9'd0;
    logic        enable = 1'b0;
    logic        ram_busy = 1'b0;
    logic [5:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_data;
    logic        ram_we;
    logic        vel_we = 1'b0;
    logic [4:0]  vel_index = 5'd0;
    logic [3:0]  vel_dx = 4'd0;
    logic [3:0]  vel_dy = 4'd0;
    logic        active;
    logic        frame_done;

    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [15:0] pre_data = 16'd0;
    logic [15:0] mem [64];

    int checks = 0;
    int errors = 0;

    typedef struct { int idx; int x; int y; int dx; int dy; } wr_t;
    wr_t q[$];
    int mx[N], my[N], mdx[N], mdy[N];

    always #5 clk = ~clk;

    sprite_motion_controller #(.NB(NB), .START_LINE(256), .XMAX(XMAX), .YMAX(YMAX)) dut (
        .clk(clk), .reset(rst), .hpos(hpos), .vpos(vpos), .enable(enable),
        .ram_busy(ram_busy), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_data(ram_data), .ram_we(ram_we), .vel_we(vel_we),
        .vel_index(vel_index), .vel_dx(vel_dx), .vel_dy(vel_dy),
        .active(active), .frame_done(frame_done)
    );

    // Synchronous RAM; while the renderer owns it the read port sees another word
    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_data <= mem[ram_busy ? 6'h3F : ram_addr];
    end

    function automatic logic [15:0] attr_word(int i);
        return 16'hA500 ^ 16'(i * 7);
    endfunction

    function automatic int norm(int v);
        return (v == -8) ? -7 : v;
    endfunction

    function automatic void step(input int p, input int v, input int lim,
                                 output int np, output int nv);
        int s;
        s = p + v;
        if (s < 0)        begin np = 0;   nv = -v; end
        else if (s > lim) begin np = lim; nv = -v; end
        else              begin np = s;   nv = v;  end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected write sequence for one full pass
    task automatic build_queue();
        wr_t e;
        int dy;
        q.delete();
        for (int i = 0; i < N; i++) begin
            dy = mdy[i];
`ifdef SPRITE_MOTION_GRAVITY_EN
            dy = (dy < 7) ? dy + 1 : 7;
`endif
            e.idx = i;
            step(mx[i], mdx[i], XMAX, e.x, e.dx);
            step(my[i], dy, YMAX, e.y, e.dy);
            q.push_back(e);
        end
    endtask

    // Every write must match the model, in order, and never during ram_busy
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (ram_we) begin
                checks++;
                if (ram_busy) begin
                    errors++;
                    $display("FAIL we_while_busy: ram_we=1 with ram_busy=1 addr %0d", ram_addr);
                end else if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h, expected none", ram_addr, ram_din);
                end else begin
                    e = q.pop_front();
                    if (ram_addr != 6'(e.idx * 2) || ram_din != {8'(e.y), 8'(e.x)}) begin
                        errors++;
                        $display("FAIL write: addr %0d data %h expected addr %0d data %h",
                                 ram_addr, ram_din, e.idx * 2, {8'(e.y), 8'(e.x)});
                    end
                    mx[e.idx] = e.x; my[e.idx] = e.y; mdx[e.idx] = e.dx; mdy[e.idx] = e.dy;
                end
            end
            if (frame_done) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL frame_done_early: %0d writes outstanding, expected 0", q.size());
                end
            end
        end
    end

    task automatic set_vel(input int i, input int dx, input int dy);
        vel_we = 1'b1; vel_index = 5'(i); vel_dx = 4'(dx); vel_dy = 4'(dy);
        @(posedge clk); #1;
        vel_we = 1'b0;
        mdx[i] = norm(dx); mdy[i] = norm(dy);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_pos"}, mem[2*i], {8'(my[i]), 8'(mx[i])});
            check({tag, "_attr"}, mem[2*i+1], attr_word(i));
        end
    endtask

    // One pass: launch, optional stall / coincident vel write / relaunch / reset
    task automatic run_pass(input int stall_at, input bit do_vel, input int relaunch_at,
                            input int reset_at, output int fcyc);
        int  pulses;
        bit  vel_hit;
        fcyc = 0; pulses = 0;
        build_queue();
        enable = 1'b1; vpos = 9'd256; hpos = 9'd0;
        @(posedge clk); #1;
        vpos = 9'd257; hpos = 9'd1;
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (stall_at != 0 && cyc == stall_at)      ram_busy = 1'b1;
            if (stall_at != 0 && cyc == stall_at + 10) ram_busy = 1'b0;
            if (relaunch_at != 0 && cyc == relaunch_at)     begin vpos = 9'd256; hpos = 9'd0; end
            if (relaunch_at != 0 && cyc == relaunch_at + 1) begin vpos = 9'd258; hpos = 9'd1; end
            if (cyc == 10) check("active_mid_pass", active, 1);
            if (reset_at != 0 && cyc == reset_at) begin
                rst = 1'b1; #1;
                check("reset_ram_we", ram_we, 0);
                check("reset_active", active, 0);
                check("reset_frame_done", frame_done, 0);
                q.delete();
                for (int i = 0; i < N; i++) begin mdx[i] = 0; mdy[i] = 0; end
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            @(negedge clk);
            if (frame_done) begin pulses++; if (fcyc == 0) fcyc = cyc; end
            vel_hit = do_vel && ram_we && (ram_addr == 6'd8);
            if (vel_hit) begin vel_we = 1'b1; vel_index = 5'd4; vel_dx = 4'b1101; vel_dy = 4'd0; end
            @(posedge clk); #1;
            if (vel_hit) begin vel_we = 1'b0; mdx[4] = -3; mdy[4] = 0; end
            if (fcyc != 0 && cyc == fcyc + 3) break;
        end
        check("frame_done_seen", int'(fcyc != 0), 1);
        check("frame_done_pulses", pulses, 1);
        check("active_after_pass", active, 0);
    endtask

    initial begin
        int fc;
        int v;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we", ram_we, 0);
        check("rst_active", active, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            mx[i] = $urandom_range(0, 255);
            my[i] = $urandom_range(0, 255);
        end
        mx[0] = 8'h20; my[0] = 8'h10;
        mx[1] = 238;   my[1] = 50;
        mx[2] = 10;    my[2] = 1;
        mx[3] = 50;    my[3] = 60;
        mx[4] = 238;   my[4] = 80;
        mx[6] = 100;   my[6] = 100;
        mx[7] = 20;    my[7] = 100;
        mx[8] = 250;   my[8] = 30;
        for (int a = 0; a < 64; a++) begin
            pre_we = 1'b1; pre_addr = 6'(a);
            pre_data = a[0] ? attr_word(a / 2) : {8'(my[a/2]), 8'(mx[a/2])};
            @(posedge clk); #1;
        end
        pre_we = 1'b0;

        for (int i = 0; i < N; i++) begin
            v = int'($urandom_range(0, 15)) - 8;
            case (i)
                0: set_vel(i, 3, -2);
                1: set_vel(i, 5, 0);
                2: set_vel(i, 0, -7);
                3: set_vel(i, 1, 1);
                4: set_vel(i, 5, 0);
                6: set_vel(i, -8, 0);
                7: set_vel(i, 0, 0);
                8: set_vel(i, 0, 0);
                default: set_vel(i, v, -v);
            endcase
        end

        // Pass 1: plain pass, ignored relaunch, coincident vel write on sprite 4
        run_pass(0, 1'b1, 50, 0, fc);
        check("pass1_frame_cycle", fc, 193);
`ifdef SPRITE_MOTION_GRAVITY_EN
        check("s0_word", mem[0], 16'h0F23);
        check("s7_gravity_y", mem[14][15:8], 101);
`else
        check("s0_word", mem[0], 16'h0E23);
        check("s7_word", mem[14], 16'h6414);
`endif
        check("s1_bounce_x", mem[2][7:0], 240);
        check("s2_bounce_y", mem[4][15:8], 0);
        check("s4_bounce_x", mem[8][7:0], 240);
        check("s6_clipped_vel_x", mem[12][7:0], 93);
        check("s8_oob_start_x", mem[16][7:0], 240);
        check_mem("pass1");

        // Pass 2: renderer holds the RAM for 10 cycles in sprite 3 WAIT
        run_pass(20, 1'b0, 0, 0, fc);
        check("pass2_frame_cycle", fc, 204);
        check("s1_second_x", mem[2][7:0], 235);
        check("s2_second_y", mem[4][15:8], 7);
        check("s4_external_vel_x", mem[8][7:0], 237);
`ifdef SPRITE_MOTION_GRAVITY_EN
        check("s3_stall_word", mem[6], 16'h4134);
`else
        check("s3_stall_word", mem[6], 16'h3E34);
`endif
        check_mem("pass2");

        // Launch condition with enable low must not start a pass
        enable = 1'b0; vpos = 9'd256; hpos = 9'd0;
        @(posedge clk); #1;
        hpos = 9'd1;
        repeat (4) @(posedge clk);
        #1;
        check("disabled_no_launch", active, 0);

        run_pass(0, 1'b0, 0, 0, fc);
        check("pass3_frame_cycle", fc, 193);
        check_mem("pass3");

        // Pass 4 is cut by reset during sprite 5; pass 5 must move nothing
        run_pass(0, 1'b0, 0, 33, fc);
        check_mem("after_reset");
        run_pass(0, 1'b0, 0, 0, fc);
        check("pass5_frame_cycle", fc, 193);
        check_mem("pass5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
